// File: rtl/servisia_gpi.sv
// Wishbone general-purpose input block: per-pin synchronizer and debouncer,
// sticky rise/fall flags with write-1-to-clear, and a masked level interrupt.
module servisia_gpi #(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [1:0]       wb_adr_i,
    input  logic [WIDTH-1:0] wb_dat_i,
    input  logic             wb_we_i,
    input  logic             wb_stb_i,
    output logic [WIDTH-1:0] wb_rdt_o,
    output logic             wb_ack_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic             irq_o
);

    localparam int              CW       = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE - 1);

    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_RISE   = 2'd1;
    localparam logic [1:0] ADR_FALL   = 2'd2;
    localparam logic [1:0] ADR_IRQ_EN = 2'd3;

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] stable_dly_q, stable_dly_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] irq_en_q, irq_en_d;
    logic [WIDTH-1:0] rdt_q, rdt_d;
    logic             ack_q, ack_d;
    logic             irq_q, irq_d;

    logic             access;
    logic [WIDTH-1:0] rise_clr, fall_clr;
    logic [WIDTH-1:0] rd_sel;

    // Two-flop synchronizer; only sync2_q is ever used downstream.
    always_comb begin
        sync1_d = gpio_i;
        sync2_d = sync1_q;
    end

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // A bus access is taken once per transaction: strobe high, ack not yet given.
    always_comb begin
        access       = wb_stb_i & ~ack_q;
        ack_d        = access;
        rise_clr     = (access && wb_we_i && wb_adr_i == ADR_RISE) ? wb_dat_i : '0;
        fall_clr     = (access && wb_we_i && wb_adr_i == ADR_FALL) ? wb_dat_i : '0;
        stable_dly_d = stable_q;
        // Set terms are OR-ed in last so a same-cycle edge beats the clear.
        rise_d       = (rise_q & ~rise_clr) | (stable_q & ~stable_dly_q);
        fall_d       = (fall_q & ~fall_clr) | (~stable_q & stable_dly_q);
        irq_en_d     = (access && wb_we_i && wb_adr_i == ADR_IRQ_EN) ? wb_dat_i : irq_en_q;
        irq_d        = |((rise_q | fall_q) & irq_en_q);
    end

    always_comb begin
        rd_sel = '0;
        case (wb_adr_i)
            ADR_DATA:   rd_sel = stable_q;
            ADR_RISE:   rd_sel = rise_q;
            ADR_FALL:   rd_sel = fall_q;
            ADR_IRQ_EN: rd_sel = irq_en_q;
            default:    rd_sel = '0;
        endcase
        rdt_d = (access && !wb_we_i) ? rd_sel : rdt_q;
    end

    // NOTE: state flops use non-blocking assignments so all of them update together.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stable_q     <= '0;
            stable_dly_q <= '0;
            rise_q       <= '0;
            fall_q       <= '0;
            irq_en_q     <= '0;
            rdt_q        <= '0;
            ack_q        <= 1'b0;
            irq_q        <= 1'b0;
            // NOTE: the counter array is per-pin control state, not storage, so it is reset.
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            irq_en_q     <= irq_en_d;
            rdt_q        <= rdt_d;
            ack_q        <= ack_d;
            irq_q        <= irq_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign wb_rdt_o = rdt_q;
    assign wb_ack_o = ack_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_servisia_gpi.sv
// Self-checking bench for servisia_gpi: directed scenarios plus random pins and
// bus traffic, all compared every cycle against a sample-window reference model.
module tb_servisia_gpi;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk  = 1'b0;
    logic         rst  = 1'b0;
    logic [1:0]   adr  = '0;
    logic [W-1:0] dat  = '0;
    logic         we   = 1'b0;
    logic         stb  = 1'b0;
    logic [W-1:0] gpio = '0;
    logic [W-1:0] rdt;
    logic         ack;
    logic         irq;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    servisia_gpi #(.WIDTH(W), .DEBOUNCE(D)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wb_adr_i (adr),
        .wb_dat_i (dat),
        .wb_we_i  (we),
        .wb_stb_i (stb),
        .wb_rdt_o (rdt),
        .wb_ack_o (ack),
        .gpio_i   (gpio),
        .irq_o    (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model. A pin's stable value flips once the last D synchronized
    // samples all disagree with it; synchronized = pin sampled two edges earlier.
    typedef struct packed {
        logic [D+1:0][W-1:0] hist;
        logic [W-1:0]        stable;
        logic [W-1:0]        stable_d;
        logic [W-1:0]        rise;
        logic [W-1:0]        fall;
        logic [W-1:0]        en;
        logic [W-1:0]        rdt;
        logic                ack;
        logic                irq;
    } model_t;

    model_t m;

    function automatic model_t model_step(model_t c, logic s, logic w, logic [1:0] a,
                                          logic [W-1:0] d, logic [W-1:0] g);
        model_t n = c;
        logic   acc = s & ~c.ack;
        logic   all_diff;
        n.hist = {c.hist[D:0], g};
        for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            for (int j = 2; j <= D + 1; j++) begin
                if (n.hist[j][b] == c.stable[b]) all_diff = 1'b0;
            end
            if (all_diff) n.stable[b] = ~c.stable[b];
        end
        n.stable_d = c.stable;
        if (acc && w && a == 2'd1) n.rise = n.rise & ~d;
        if (acc && w && a == 2'd2) n.fall = n.fall & ~d;
        if (acc && w && a == 2'd3) n.en = d;
        n.rise = n.rise | (c.stable & ~c.stable_d);
        n.fall = n.fall | (~c.stable & c.stable_d);
        if (acc && !w) begin
            case (a)
                2'd0:    n.rdt = c.stable;
                2'd1:    n.rdt = c.rise;
                2'd2:    n.rdt = c.fall;
                default: n.rdt = c.en;
            endcase
        end
        n.ack = acc;
        n.irq = |((c.rise | c.fall) & c.en);
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= '0;
        else     m <= model_step(m, stb, we, adr, dat, gpio);
    end

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("mon_ack", ack, m.ack);
            check("mon_irq", irq, m.irq);
            check("mon_rdt", rdt, m.rdt);
        end
    end

    // One Wishbone access starting at the next falling edge; ack must follow
    // exactly one cycle later.
    task automatic bus(input logic [1:0] a, input logic w, input logic [W-1:0] d,
                       output logic [W-1:0] r);
        int n = 0;
        @(negedge clk);
        adr = a; we = w; dat = d; stb = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 4);
        check("ack_latency", n, 1);
        r   = rdt;
        stb = 1'b0;
        we  = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [W-1:0] exp, input string tag);
        logic [W-1:0] r;
        bus(a, 1'b0, '0, r);
        check(tag, r, exp);
    endtask

    task automatic wr(input logic [1:0] a, input logic [W-1:0] d);
        logic [W-1:0] r;
        bus(a, 1'b1, d, r);
    endtask

    initial begin
        #500us;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        mon_en = 1'b1;
        check("rst_ack", ack, 0);
        check("rst_irq", irq, 0);
        for (int a = 0; a < 4; a++) rd(2'(a), 8'h00, "rst_read");

        // Debounce latency: stable updates on the sixth edge after the change.
        gpio = 8'h05;
        repeat (4) @(negedge clk);
        rd(2'd0, 8'h00, "data_before_latency");
        rd(2'd0, 8'h05, "data_after_latency");
        rd(2'd1, 8'h05, "rise_after_05");
        rd(2'd2, 8'h00, "fall_after_05");

        // Three-cycle glitch on bit 3 must be filtered.
        gpio = 8'h0D;
        repeat (3) @(negedge clk);
        gpio = 8'h05;
        repeat (10) @(negedge clk);
        rd(2'd0, 8'h05, "data_after_glitch");
        rd(2'd1, 8'h05, "rise_after_glitch");

        gpio = 8'h00;
        repeat (10) @(negedge clk);
        rd(2'd2, 8'h05, "fall_after_release");
        wr(2'd2, 8'h01);
        rd(2'd2, 8'h04, "fall_w1c_bit0");
        wr(2'd2, 8'hFF);
        rd(2'd2, 8'h00, "fall_w1c_all");

        wr(2'd3, 8'h04);
        @(negedge clk);
        check("irq_set", irq, 1);
        wr(2'd1, 8'h04);
        @(negedge clk);
        check("irq_cleared", irq, 0);
        rd(2'd1, 8'h01, "rise_bit0_kept");

        // W1C of RISE bit 1 sampled on the same edge its set term is active.
        gpio = 8'h02;
        repeat (5) @(negedge clk);
        wr(2'd1, 8'h02);
        rd(2'd1, 8'h03, "rise_set_wins");
        wr(2'd1, 8'h02);
        rd(2'd1, 8'h01, "rise_w1c_bit1");

        // Asynchronous reset in the middle of an acked strobe.
        gpio = 8'h00;
        repeat (10) @(negedge clk);
        wr(2'd3, 8'h03);
        repeat (2) @(negedge clk);
        check("irq_before_rst", irq, 1);
        adr = 2'd0; we = 1'b0; stb = 1'b1;
        @(posedge clk);
        #2;
        check("ack_before_rst", ack, 1);
        rst = 1'b1;
        #1;
        check("ack_async_rst", ack, 0);
        check("irq_async_rst", irq, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (!ack && n < 4) begin
            @(negedge clk);
            n++;
        end
        check("reack_after_rst", ack, 1);
        stb = 1'b0;
        rd(2'd1, 8'h00, "rise_after_rst");
        rd(2'd2, 8'h00, "fall_after_rst");
        rd(2'd3, 8'h00, "en_after_rst");

        // Random pins and bus traffic; the monitor does the comparing.
        for (int i = 0; i < 500; i++) begin
            logic [W-1:0] r;
            case ($urandom_range(3))
                0:       gpio = gpio ^ W'($urandom);
                1, 2:    bus(2'($urandom_range(3)), 1'($urandom_range(1)), W'($urandom), r);
                default: repeat ($urandom_range(1, 6)) @(negedge clk);
            endcase
        end
        repeat (12) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
